// File: rtl/bcd_disp_pkg.sv
// Shared constants and helpers for the BCD scan counter: segment patterns,
// polarity handling and a width helper for the prescaler/scan counters.
package bcd_disp_pkg;

  // Segment patterns {a,b,c,d,e,f,g}, active-low form (0 = lit).
  localparam logic [6:0] SEG_0     = 7'b0000001;
  localparam logic [6:0] SEG_1     = 7'b1001111;
  localparam logic [6:0] SEG_2     = 7'b0010010;
  localparam logic [6:0] SEG_3     = 7'b0000110;
  localparam logic [6:0] SEG_4     = 7'b1001100;
  localparam logic [6:0] SEG_5     = 7'b0100100;
  localparam logic [6:0] SEG_6     = 7'b0100000;
  localparam logic [6:0] SEG_7     = 7'b0001111;
  localparam logic [6:0] SEG_8     = 7'b0000000;
  localparam logic [6:0] SEG_9     = 7'b0000100;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  // Bits needed to hold 0..value-1 (never less than one).
  function automatic int clog2(input int value);
    int w;
    w = 1;
    while ((1 << w) < value) w++;
    return w;
  endfunction

  // Pattern for a digit, blanked on request or for non-BCD codes.
  function automatic logic [6:0] seg_pattern(input logic [3:0] digit,
                                             input logic       blank,
                                             input bit         active_low);
    logic [6:0] pat;
    case (digit)
      4'd0:    pat = SEG_0;
      4'd1:    pat = SEG_1;
      4'd2:    pat = SEG_2;
      4'd3:    pat = SEG_3;
      4'd4:    pat = SEG_4;
      4'd5:    pat = SEG_5;
      4'd6:    pat = SEG_6;
      4'd7:    pat = SEG_7;
      4'd8:    pat = SEG_8;
      4'd9:    pat = SEG_9;
      default: pat = SEG_BLANK;
    endcase
    if (blank) pat = SEG_BLANK;
    return active_low ? pat : ~pat;
  endfunction

endpackage

// File: rtl/bcd_digit_cell.sv
// One BCD digit with load, ripple increment/decrement and carry chain.
// carry_out means "this digit and every lower one sit at the terminal value".
module bcd_digit_cell (
  input  logic       clk,
  input  logic       rst,
  input  logic       load,
  input  logic [3:0] load_digit,
  input  logic       step,
  input  logic       up_dn,
  input  logic       carry_in,
  output logic [3:0] digit,
  output logic       carry_out
);

  logic [3:0] digit_next;

  always_comb begin
    digit_next = digit;
    if (load) begin
      digit_next = (load_digit > 4'd9) ? 4'd0 : load_digit;
    end else if (step && carry_in) begin
      if (up_dn) digit_next = (digit == 4'd9) ? 4'd0 : digit + 4'd1;
      else       digit_next = (digit == 4'd0) ? 4'd9 : digit - 4'd1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) digit <= 4'd0;
    else      digit <= digit_next;
  end

  assign carry_out = carry_in && (up_dn ? (digit == 4'd9) : (digit == 4'd0));

endmodule

// File: rtl/bcd_scan_counter.sv
// N-digit BCD up/down counter with tick prescaler, parallel load, wrap pulse,
// leading-zero blanking and a registered multiplexed 7-segment drive.
module bcd_scan_counter
  import bcd_disp_pkg::*;
#(
  parameter int FREQ_CLK       = 50000000,
  parameter int N_DIGITS       = 4,
  parameter int COUNT_HZ       = 4,
  parameter int SLOT_HZ        = 1000,
  parameter int SEG_ACTIVE_LOW = 1,
  parameter int SEL_ACTIVE_LOW = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  enable,
  input  logic                  up_dn,
  input  logic                  load,
  input  logic [4*N_DIGITS-1:0] load_val,
  input  logic                  blank_lz,
  output logic [4*N_DIGITS-1:0] count_bcd,
  output logic                  wrap,
  output logic [6:0]            seg_out,
  output logic [N_DIGITS-1:0]   digit_sel
);

  localparam int TP = FREQ_CLK / COUNT_HZ;
  localparam int SP = FREQ_CLK / SLOT_HZ;
  localparam int PW = clog2(TP);
  localparam int SW = clog2(SP);
  localparam int IW = clog2(N_DIGITS);
  localparam logic [PW-1:0] TP_LAST  = PW'(TP - 1);
  localparam logic [SW-1:0] SP_LAST  = SW'(SP - 1);
  localparam logic [IW-1:0] IDX_LAST = IW'(N_DIGITS - 1);
  localparam logic [6:0]    SEG_OFF  = seg_pattern(4'd0, 1'b1, SEG_ACTIVE_LOW != 0);
  localparam logic [N_DIGITS-1:0] SEL_OFF = (SEL_ACTIVE_LOW != 0) ? '1 : '0;

  generate
    if (TP < 2 || SP < 2 || N_DIGITS < 2 || N_DIGITS > 8) begin : g_bad_params
      $error("bcd_scan_counter: need TP>=2, SP>=2 and 2<=N_DIGITS<=8");
    end
  endgenerate

  logic [PW-1:0] presc;
  logic          tick;
  logic          step;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)      presc <= '0;
    else if (tick) presc <= '0;
    else           presc <= presc + PW'(1);
  end

  assign tick = (presc == TP_LAST);
  assign step = tick && enable;

  logic [3:0] digit [N_DIGITS];

  // Carries pass through per-stage wires so the chain is not one self-feeding vector.
  generate
    for (genvar gi = 0; gi < N_DIGITS; gi++) begin : g_digit
      logic cin;
      logic cout;
      if (gi == 0) begin : g_lsd
        assign cin = 1'b1;
      end else begin : g_chain
        assign cin = g_digit[gi-1].cout;
      end
      bcd_digit_cell u_cell (
        .clk        (clk),
        .rst        (rst),
        .load       (load),
        .load_digit (load_val[4*gi +: 4]),
        .step       (step),
        .up_dn      (up_dn),
        .carry_in   (cin),
        .digit      (digit[gi]),
        .carry_out  (cout)
      );
      assign count_bcd[4*gi +: 4] = digit[gi];
    end
  endgenerate

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) wrap <= 1'b0;
    else      wrap <= !load && step && g_digit[N_DIGITS-1].cout;
  end

  logic [SW-1:0] slot_cnt;
  logic [IW-1:0] slot_idx;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      slot_cnt <= '0;
      slot_idx <= '0;
    end else if (slot_cnt == SP_LAST) begin
      slot_cnt <= '0;
      slot_idx <= (slot_idx == IDX_LAST) ? '0 : slot_idx + IW'(1);
    end else begin
      slot_cnt <= slot_cnt + SW'(1);
    end
  end

  // lz[i]: digit i and every higher digit are zero.
  logic [N_DIGITS-1:0] lz;
  logic                run;

  always_comb begin
    lz  = '0;
    run = 1'b1;
    for (int i = N_DIGITS - 1; i >= 0; i--) begin
      run   = run && (digit[i] == 4'd0);
      lz[i] = run;
    end
  end

  logic [N_DIGITS-1:0] sel_onehot;
  logic [3:0]          cur_digit;
  logic                cur_blank;
  logic [6:0]          seg_next;
  logic [N_DIGITS-1:0] sel_next;

  always_comb begin
    sel_onehot = '0;
    cur_digit  = 4'd0;
    cur_blank  = 1'b0;
    for (int i = 0; i < N_DIGITS; i++) begin
      if (slot_idx == IW'(i)) begin
        sel_onehot[i] = 1'b1;
        cur_digit     = digit[i];
        cur_blank     = (i != 0) && lz[i];
      end
    end
    sel_next = (SEL_ACTIVE_LOW != 0) ? ~sel_onehot : sel_onehot;
    seg_next = seg_pattern(cur_digit, blank_lz && cur_blank, SEG_ACTIVE_LOW != 0);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      seg_out   <= SEG_OFF;
      digit_sel <= SEL_OFF;
    end else begin
      seg_out   <= seg_next;
      digit_sel <= sel_next;
    end
  end

endmodule

// File: tb/tb_bcd_scan_counter.sv
// Self-checking bench for bcd_scan_counter (TP=10, SP=4, 4 digits): cycle-stamped
// expectations sit in a sorted queue and are compared as the DUT reaches each cycle.
module tb_bcd_scan_counter;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        enable = 1'b0;
  logic        up_dn = 1'b1;
  logic        load = 1'b0;
  logic [15:0] load_val = '0;
  logic        blank_lz = 1'b0;
  logic [15:0] count_bcd;
  logic        wrap;
  logic [6:0]  seg_out;
  logic [3:0]  digit_sel;

  bcd_scan_counter #(
    .FREQ_CLK       (80),
    .N_DIGITS       (4),
    .COUNT_HZ       (8),
    .SLOT_HZ        (20),
    .SEG_ACTIVE_LOW (1),
    .SEL_ACTIVE_LOW (1)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .enable    (enable),
    .up_dn     (up_dn),
    .load      (load),
    .load_val  (load_val),
    .blank_lz  (blank_lz),
    .count_bcd (count_bcd),
    .wrap      (wrap),
    .seg_out   (seg_out),
    .digit_sel (digit_sel)
  );

  always #5 clk = ~clk;

  typedef enum int {F_COUNT, F_WRAP, F_SEG, F_SEL} field_e;
  typedef struct {
    int          at;
    field_e      field;
    logic [15:0] value;
    string       name;
  } exp_t;

  typedef struct {
    string       name;
    int          drive;
    logic        ld;
    logic [15:0] lv;
    logic        en;
    logic        ud;
    int          chk;
    logic [15:0] exp_count;
    logic        exp_wrap;
  } vec_t;

  exp_t sb[$];
  vec_t vecs[12];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  logic [6:0] seg_tbl [0:9] = '{7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
                                7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
                                7'b0000000, 7'b0000100};
  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at cycle %0d: got %h, expected %h", name, cyc, act, exp);
    end else begin
      $display("check %s at cycle %0d: %h ok", name, cyc, act);
    end
  endtask

  task automatic expect_at(input int at, input field_e f, input logic [15:0] v, input string name);
    exp_t e;
    int   pos;
    e.at = at; e.field = f; e.value = v; e.name = name;
    pos = sb.size();
    for (int i = 0; i < sb.size(); i++) begin
      if (sb[i].at > at) begin
        pos = i;
        break;
      end
    end
    sb.insert(pos, e);
  endtask

  task automatic drain();
    while (sb.size() > 0 && sb[0].at <= cyc) begin
      exp_t e;
      e = sb.pop_front();
      if (e.at < cyc) begin
        checks++;
        errors++;
        $display("FAIL %s: expectation for cycle %0d missed (now %0d)", e.name, e.at, cyc);
      end else begin
        case (e.field)
          F_COUNT: check(e.name, count_bcd, e.value);
          F_WRAP:  check(e.name, {15'b0, wrap}, e.value);
          F_SEG:   check(e.name, {9'b0, seg_out}, e.value);
          default: check(e.name, {12'b0, digit_sel}, e.value);
        endcase
      end
    end
  endtask

  task automatic advance(input int n);
    repeat (n) begin
      @(posedge clk);
      cyc++;
      @(negedge clk);
      drain();
    end
  endtask

  task automatic advance_to(input int target);
    if (target > cyc) advance(target - cyc);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0]  = '{"load_9998",      121, 1'b1, 16'h9998, 1'b1, 1'b1, 122, 16'h9998, 1'b0};
    vecs[1]  = '{"up_to_9999",     122, 1'b0, 16'h0000, 1'b1, 1'b1, 130, 16'h9999, 1'b0};
    vecs[2]  = '{"up_wrap",        130, 1'b0, 16'h0000, 1'b1, 1'b1, 140, 16'h0000, 1'b1};
    vecs[3]  = '{"wrap_one_cycle", 140, 1'b0, 16'h0000, 1'b1, 1'b1, 141, 16'h0000, 1'b0};
    vecs[4]  = '{"load_0000",      141, 1'b1, 16'h0000, 1'b1, 1'b0, 142, 16'h0000, 1'b0};
    vecs[5]  = '{"down_wrap",      142, 1'b0, 16'h0000, 1'b1, 1'b0, 150, 16'h9999, 1'b1};
    vecs[6]  = '{"down_wrap_end",  150, 1'b0, 16'h0000, 1'b1, 1'b0, 151, 16'h9999, 1'b0};
    vecs[7]  = '{"down_step",      151, 1'b0, 16'h0000, 1'b1, 1'b0, 160, 16'h9998, 1'b0};
    vecs[8]  = '{"load_beats_tick",199, 1'b1, 16'h0A5F, 1'b1, 1'b1, 200, 16'h0050, 1'b0};
    vecs[9]  = '{"disabled_ticks", 200, 1'b0, 16'h0000, 1'b0, 1'b1, 231, 16'h0050, 1'b0};
    vecs[10] = '{"no_queued_tick", 231, 1'b0, 16'h0000, 1'b1, 1'b1, 239, 16'h0050, 1'b0};
    vecs[11] = '{"resume_count",   239, 1'b0, 16'h0000, 1'b1, 1'b1, 240, 16'h0051, 1'b0};

    // Power-on reset state
    @(negedge clk);
    check("rst_count", count_bcd, 16'h0000);
    check("rst_wrap", {15'b0, wrap}, 16'h0000);
    check("rst_seg", {9'b0, seg_out}, {9'b0, SEG_BLANK});
    check("rst_sel", {12'b0, digit_sel}, 16'h000F);

    // Free-running count and scan after release
    enable = 1'b1; up_dn = 1'b1; rst = 1'b1; cyc = 0;
    for (int k = 1; k <= 17; k++)
      expect_at(k, F_SEL, 16'(~(4'b0001 << (((k - 1) / 4) % 4)) & 4'hF), "scan_sel");
    expect_at(9,   F_COUNT, 16'h0000, "before_first_tick");
    expect_at(10,  F_COUNT, 16'h0001, "first_tick");
    expect_at(10,  F_WRAP,  16'h0000, "first_tick_wrap");
    expect_at(113, F_SEG,   {9'b0, seg_tbl[1]}, "seg_slot0_one");
    expect_at(117, F_SEG,   {9'b0, seg_tbl[1]}, "seg_slot1_one");
    expect_at(119, F_COUNT, 16'h0011, "count_119");
    expect_at(120, F_COUNT, 16'h0012, "count_120");
    expect_at(121, F_SEG,   {9'b0, seg_tbl[0]}, "seg_slot2_zero");
    advance_to(121);

    // Table: loads, wraps, load-vs-tick priority, discarded ticks
    for (int i = 0; i < 12; i++) begin
      advance_to(vecs[i].drive);
      load = vecs[i].ld; load_val = vecs[i].lv;
      enable = vecs[i].en; up_dn = vecs[i].ud;
      expect_at(vecs[i].chk, F_COUNT, vecs[i].exp_count, {vecs[i].name, "_count"});
      expect_at(vecs[i].chk, F_WRAP, {15'b0, vecs[i].exp_wrap}, {vecs[i].name, "_wrap"});
      advance(1);
      load = 1'b0;
    end
    advance_to(240);

    // Leading-zero blanking with 0x0040 held
    load = 1'b1; load_val = 16'h0040; enable = 1'b0; blank_lz = 1'b1;
    expect_at(246, F_SEG, {9'b0, seg_tbl[4]}, "lz_slot1");
    expect_at(246, F_SEL, 16'h000D, "lz_sel1");
    expect_at(250, F_SEG, {9'b0, SEG_BLANK}, "lz_slot2");
    expect_at(250, F_SEL, 16'h000B, "lz_sel2");
    expect_at(254, F_SEG, {9'b0, SEG_BLANK}, "lz_slot3");
    expect_at(254, F_SEL, 16'h0007, "lz_sel3");
    expect_at(258, F_SEG, {9'b0, seg_tbl[0]}, "lz_slot0");
    expect_at(258, F_SEL, 16'h000E, "lz_sel0");
    advance(1);
    load = 1'b0;
    advance_to(260);
    blank_lz = 1'b0;
    expect_at(266, F_SEG, {9'b0, seg_tbl[0]}, "nolz_slot2");
    expect_at(270, F_SEG, {9'b0, seg_tbl[0]}, "nolz_slot3");
    advance_to(272);

    // Reset in the middle of a slot
    load = 1'b1; load_val = 16'h1234;
    expect_at(274, F_COUNT, 16'h1234, "pre_reset_count");
    advance(1);
    load = 1'b0;
    advance_to(274);
    #2;
    rst = 1'b0;
    #1;
    check("midrst_count", count_bcd, 16'h0000);
    check("midrst_wrap", {15'b0, wrap}, 16'h0000);
    check("midrst_seg", {9'b0, seg_out}, {9'b0, SEG_BLANK});
    check("midrst_sel", {12'b0, digit_sel}, 16'h000F);
    @(posedge clk);
    @(negedge clk);
    check("held_rst_count", count_bcd, 16'h0000);
    check("held_rst_sel", {12'b0, digit_sel}, 16'h000F);
    enable = 1'b1; up_dn = 1'b1; rst = 1'b1; cyc = 0;
    expect_at(1,  F_SEL,   16'h000E, "rel_sel_1");
    expect_at(1,  F_SEG,   {9'b0, seg_tbl[0]}, "rel_seg_1");
    expect_at(4,  F_SEL,   16'h000E, "rel_sel_4");
    expect_at(5,  F_SEL,   16'h000D, "rel_sel_5");
    expect_at(9,  F_COUNT, 16'h0000, "rel_count_9");
    expect_at(10, F_COUNT, 16'h0001, "rel_count_10");
    advance(11);

    if (sb.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL scoreboard: %0d expectations never reached", sb.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
